// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared segment constants, score limit and monitor state encoding
package scoreboard_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/seg7_digit_decoder.sv
// rtl/seg7_digit_decoder.sv - combinational 7-segment pattern to BCD digit decoder
module seg7_digit_decoder
    import scoreboard_pkg::*;
(
    input  logic [6:0] seg,
    input  logic       blank_is_zero,
    output logic [3:0] digit,
    output logic       valid
);

    // Map a legal pattern to its digit; a blank only counts as zero when allowed
    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: valid = blank_is_zero;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_score_monitor.sv
// rtl/seg7_score_monitor.sv - debounces and decodes a two-digit 7-segment display, classifies score changes
module seg7_score_monitor
    import scoreboard_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)
(
    input  logic       clk_1khz_i,
    input  logic       rst_i,
    input  logic [6:0] seg_tens_i,
    input  logic [6:0] seg_ones_i,
    output logic [6:0] score_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       change_o,
    output logic       inc_o,
    output logic       clr_o,
    output logic       jump_o,
    output logic [7:0] fault_cnt_o
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [13:0] pattern;
    logic [13:0] sample_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        accept;

    logic [6:0]  tens_seg;
    logic [6:0]  ones_seg;
    logic [3:0]  tens_digit;
    logic [3:0]  ones_digit;
    logic        tens_valid;
    logic        ones_valid;
    logic        pair_valid;
    logic [6:0]  new_score;
    logic [6:0]  inc_target;

    mon_state_t  state_q;
    mon_state_t  state_d;
    logic [6:0]  score_q, score_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        change_q, change_d;
    logic        inc_q, inc_d;
    logic        clr_q, clr_d;
    logic        jump_q, jump_d;
    logic [7:0]  fault_q, fault_d;

    assign pattern = {seg_tens_i, seg_ones_i};

    // Stability counter: restart on any difference, saturate once the pattern is trusted
    always_comb begin
        cnt_d = cnt_q;
        if (pattern != sample_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q != STABLE_LIM) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fire exactly once per stable period, on the edge the counter reaches the limit
    assign accept = (cnt_d == STABLE_LIM) && (cnt_q != STABLE_LIM);

    // Register the raw bus pair and the stability count every cycle
    always_ff @(posedge clk_1khz_i) begin
        if (rst_i) begin
            sample_q <= 14'd0;
            cnt_q    <= 8'd0;
        end else begin
            sample_q <= pattern;
            cnt_q    <= cnt_d;
        end
    end

    assign tens_seg = SEG_ACTIVE_LOW ? ~seg_tens_i : seg_tens_i;
    assign ones_seg = SEG_ACTIVE_LOW ? ~seg_ones_i : seg_ones_i;

    seg7_digit_decoder u_tens_dec (
        .seg           (tens_seg),
        .blank_is_zero (1'b1),
        .digit         (tens_digit),
        .valid         (tens_valid)
    );

    seg7_digit_decoder u_ones_dec (
        .seg           (ones_seg),
        .blank_is_zero (1'b0),
        .digit         (ones_digit),
        .valid         (ones_valid)
    );

    assign pair_valid = tens_valid && ones_valid;
    assign new_score  = ({3'd0, tens_digit} * 7'd10) + {3'd0, ones_digit};
    // A 99 -> 0 rollover is a normal increment, not a clear
    assign inc_target = (score_q == SCORE_MAX) ? 7'd0 : score_q + 7'd1;

    // Next-state and next-output logic, evaluated only on an accepted pattern
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        valid_d  = valid_q;
        err_d    = err_q;
        fault_d  = fault_q;
        change_d = 1'b0;
        inc_d    = 1'b0;
        clr_d    = 1'b0;
        jump_d   = 1'b0;
        if (accept) begin
            case (state_q)
                ST_WAIT: begin
                    if (pair_valid) begin
                        state_d  = ST_LOCKED;
                        score_d  = new_score;
                        valid_d  = 1'b1;
                        change_d = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        fault_d = (fault_q == 8'hFF) ? fault_q : fault_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (pair_valid) begin
                        if (new_score != score_q) begin
                            score_d  = new_score;
                            change_d = 1'b1;
                            if (new_score == inc_target) begin
                                inc_d = 1'b1;
                            end else if (new_score == 7'd0) begin
                                clr_d = 1'b1;
                            end else begin
                                jump_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_FAULT;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        fault_d = (fault_q == 8'hFF) ? fault_q : fault_q + 8'd1;
                    end
                end
                ST_FAULT: begin
                    if (pair_valid) begin
                        state_d  = ST_LOCKED;
                        score_d  = new_score;
                        valid_d  = 1'b1;
                        err_d    = 1'b0;
                        change_d = (new_score != score_q);
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_1khz_i) begin
        if (rst_i) begin
            state_q  <= ST_WAIT;
            score_q  <= 7'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 8'd0;
            change_q <= 1'b0;
            inc_q    <= 1'b0;
            clr_q    <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
            change_q <= change_d;
            inc_q    <= inc_d;
            clr_q    <= clr_d;
            jump_q   <= jump_d;
        end
    end

    assign score_o     = score_q;
    assign valid_o     = valid_q;
    assign err_o       = err_q;
    assign change_o    = change_q;
    assign inc_o       = inc_q;
    assign clr_o       = clr_q;
    assign jump_o      = jump_q;
    assign fault_cnt_o = fault_q;

endmodule

// File: tb/tb_seg7_score_monitor.sv
// tb/tb_seg7_score_monitor.sv - scoreboard bench for seg7_score_monitor
module tb_seg7_score_monitor;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [6:0] score_o;
    logic       valid_o;
    logic       err_o;
    logic       change_o;
    logic       inc_o;
    logic       clr_o;
    logic       jump_o;
    logic [7:0] fault_cnt_o;

    always #5 clk = ~clk;

    seg7_score_monitor #(
        .STABLE_CYCLES  (STABLE),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk_1khz_i  (clk),
        .rst_i       (rst_i),
        .seg_tens_i  (seg_tens),
        .seg_ones_i  (seg_ones),
        .score_o     (score_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .change_o    (change_o),
        .inc_o       (inc_o),
        .clr_o       (clr_o),
        .jump_o      (jump_o),
        .fault_cnt_o (fault_cnt_o)
    );

    typedef struct {
        int cyc;
        int score;
        int valid;
        int err;
        int change;
        int inc;
        int clr;
        int jump;
        int fcnt;
    } ev_t;

    ev_t q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic rst_q  = 1'b1;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int          m_state = 0;
    int          m_score = 0;
    int          m_valid = 0;
    int          m_err   = 0;
    int          m_fcnt  = 0;
    logic [13:0] m_last  = 14'h0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_i;
    end

    task automatic dec(input logic [6:0] s, input bit is_tens, output int d, output bit ok);
        d  = 0;
        ok = 1'b0;
        if (s == 7'h00) begin
            ok = is_tens;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (seg_tab[i] == s) begin
                    d  = i;
                    ok = 1'b1;
                end
            end
        end
    endtask

    task automatic expect_accept(input logic [6:0] t, input logic [6:0] o);
        int  dt, dd, nv;
        bit  okt, oko, push;
        ev_t e;
        dec(t, 1'b1, dt, okt);
        dec(o, 1'b0, dd, oko);
        nv       = dt * 10 + dd;
        push     = 1'b0;
        e.cyc    = cyc + STABLE;
        e.change = 0;
        e.inc    = 0;
        e.clr    = 0;
        e.jump   = 0;
        if (okt && oko) begin
            if (m_state == 0) begin
                push     = 1'b1;
                e.change = 1;
            end else if (m_state == 1) begin
                if (nv != m_score) begin
                    push     = 1'b1;
                    e.change = 1;
                    if (nv == (m_score + 1) % 100) e.inc = 1;
                    else if (nv == 0)              e.clr = 1;
                    else                           e.jump = 1;
                end
            end else begin
                push     = 1'b1;
                e.change = (nv != m_score) ? 1 : 0;
            end
            m_state = 1;
            m_score = nv;
            m_valid = 1;
            m_err   = 0;
        end else if (m_state != 2) begin
            push    = 1'b1;
            m_state = 2;
            m_valid = 0;
            m_err   = 1;
            if (m_fcnt < 255) m_fcnt++;
        end
        if (push) begin
            e.score = m_score;
            e.valid = m_valid;
            e.err   = m_err;
            e.fcnt  = m_fcnt;
            q.push_back(e);
        end
    endtask

    // Drive at the current negedge, then hold for n cycles
    task automatic hold(input logic [6:0] t, input logic [6:0] o, input int n);
        seg_tens = t;
        seg_ones = o;
        if ({t, o} != m_last) expect_accept(t, o);
        m_last = {t, o};
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_score"}, score_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_pulses"}, {change_o, inc_o, clr_o, jump_o}, 0);
        chk({tag, "_fcnt"}, fault_cnt_o, 0);
    endtask

    int  p_valid = 0;
    int  p_err   = 0;
    ev_t me;

    always @(negedge clk) begin
        if (!rst_q) begin
            if (change_o || inc_o || clr_o || jump_o ||
                (int'(valid_o) != p_valid) || (int'(err_o) != p_err)) begin
                chk("evt_expected", (q.size() != 0) ? 1 : 0, 1);
                if (q.size() != 0) begin
                    me = q.pop_front();
                    chk("evt_cycle", cyc, me.cyc);
                    chk("evt_score", score_o, me.score);
                    chk("evt_valid", valid_o, me.valid);
                    chk("evt_err", err_o, me.err);
                    chk("evt_change", change_o, me.change);
                    chk("evt_inc", inc_o, me.inc);
                    chk("evt_clr", clr_o, me.clr);
                    chk("evt_jump", jump_o, me.jump);
                    chk("evt_fcnt", fault_cnt_o, me.fcnt);
                end
            end
        end
        p_valid = int'(valid_o);
        p_err   = int'(err_o);
    end

    initial begin
        rst_i    = 1'b1;
        seg_tens = 7'h00;
        seg_ones = 7'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_i = 1'b0;

        hold(7'h00, 7'h3F, 10);     // 0, first lock
        hold(7'h00, 7'h06, 6);      // 1, inc
        hold(7'h06, 7'h3F, 6);      // 10, jump

        for (int k = 0; k < 10; k++) begin
            seg_tens = 7'h00;
            seg_ones = (k % 2 == 0) ? 7'h06 : 7'h5B;
            m_last   = {seg_tens, seg_ones};
            repeat (2) @(negedge clk);
        end
        chk("glitch_score", score_o, m_score);
        chk("glitch_valid", valid_o, m_valid);

        hold(7'h6F, 7'h6F, 6);      // 99, jump
        hold(7'h00, 7'h3F, 6);      // 0, wrap counts as inc
        hold(7'h66, 7'h5B, 6);      // 42, jump
        hold(7'h00, 7'h3F, 6);      // 0, clr
        hold(7'h66, 7'h5B, 6);      // 42, jump
        hold(7'h00, 7'h00, 6);      // illegal ones, fault with score held
        hold(7'h00, 7'h4F, 6);      // 3, recovery with change only

        seg_tens = 7'h00;
        seg_ones = 7'h5B;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst_i   = 1'b0;
        m_state = 0;
        m_score = 0;
        m_valid = 0;
        m_err   = 0;
        m_fcnt  = 0;
        m_last  = 14'h0;
        hold(7'h00, 7'h5B, 8);      // 2, fresh lock after release

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seg7_score_monitor.md
Name: seg7_score_monitor

Overview:
Receiving end of the scoreboard display interface. Samples the dual 7-segment buses, debounces them against transient or mid-update patterns, decodes them back to a binary score (0..99), and classifies every accepted change as increment, clear or jump. It is used as a self-checking observer in system benches and as an on-chip display-integrity monitor next to the display driver.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 2..255)
SEG_ACTIVE_LOW, 0, 1 = segment buses are active-low and are inverted before decoding

Ports:
clk_1khz_i  input  1  system clock, 1 kHz
rst_i  input  1  synchronous, active-high reset
seg_tens_i  input  7  tens digit segments, bit order {g,f,e,d,c,b,a}
seg_ones_i  input  7  ones digit segments, same order
score_o  output  7  last accepted score, binary 0..99
valid_o  output  1  score_o reflects a currently displayed legal pattern
err_o  output  1  high while the FAULT state is active
change_o  output  1  one-cycle pulse: accepted value differs from the previous score_o
inc_o  output  1  one-cycle pulse: new = old+1 (99->0 counts as inc)
clr_o  output  1  one-cycle pulse: new = 0, old != 0, and not a 99->0 wrap
jump_o  output  1  one-cycle pulse: any other change
fault_cnt_o  output  8  saturating count of FAULT entries

Behaviour:
- Reset, applied at any time including mid-filter: score_o=0, valid_o=0, err_o=0, all pulses=0, fault_cnt_o=0, filter counter=0, sample register=0, state=WAIT.
- Active-high segment decode, after optional inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Tens digit all-off (00) decodes as 0 (leading blank).
  - Ones digit all-off is invalid.
  - Every other pattern is invalid. The pair is invalid if either digit is invalid.
  - Score = tens*10 + ones, 7-bit.
- Filter:
  - The concatenated 14-bit pattern is registered every cycle.
  - Counter resets to 1 when the new sample differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
  - Acceptance fires once, on the edge where the counter reaches STABLE_CYCLES.
  - Latency: a pattern present before edge 1 is accepted at edge STABLE_CYCLES, and outputs are visible after that edge.
  - A pattern held longer produces no further acceptances.
- States:
  - WAIT:
    - Accepted valid pattern -> LOCKED; score_o=new, valid_o=1, change_o pulses. No inc/clr/jump pulse.
    - Accepted invalid pattern -> FAULT.
  - LOCKED:
    - Accepted valid pattern equal to score_o -> no pulse.
    - Accepted valid pattern that differs -> update score_o, pulse change_o plus exactly one of inc_o/clr_o/jump_o.
    - Accepted invalid pattern -> FAULT.
  - FAULT:
    - On entry: valid_o=0, err_o=1, score_o holds its last value, fault_cnt_o increments (saturates at 255).
    - Accepted valid pattern -> LOCKED; valid_o=1, err_o=0, score_o=new, change_o pulses if new differs from the held value. No inc/clr/jump pulse.
- Pulse rules:
  - All pulses are exactly one cycle wide and are registered, i.e. high in the cycle after the accepting edge.
  - inc/clr/jump are mutually exclusive.
  - A 0->0 re-acceptance is not possible because the filter fires only once per stable period.
- An input that toggles faster than STABLE_CYCLES never reaches acceptance, so outputs hold.

Decomposition:
- Package scoreboard_pkg:
  - the ten segment constants and the SEG_BLANK constant
  - the monitor state encoding (WAIT=2'd0, LOCKED=2'd1, FAULT=2'd2)
  - SCORE_MAX=99
- Sub-module seg7_digit_decoder: combinational; 7-bit pattern plus blank_is_zero flag in, 4-bit digit plus valid out. Instantiated once per digit.
- Filter counter, FSM and event classification stay in the top module.

Test Plan:
- Reset, then hold tens=00/ones=3F for 10 cycles (STABLE_CYCLES=4) -> score_o=0 and valid_o=1 after edge 4; change_o single pulse; no inc/clr/jump.
- From 0: tens=00/ones=06, held -> score_o=1, change_o and inc_o pulse once, 4 cycles after the change. Then tens=06/ones=3F -> score_o=10 with jump_o.
- Glitch: ones toggles 06<->5B every 2 cycles for 20 cycles -> score_o, valid_o and pulses unchanged.
- Score 99 (6F/6F), then 00/3F -> inc_o (wrap), not clr_o. Score 42, then 00/3F -> clr_o.
- Illegal ones=00 held 4 cycles -> err_o=1, valid_o=0, fault_cnt_o=1, score_o held. Then 00/4F -> valid_o=1, score_o=3, change_o only.
- rst_i asserted at filter count 3 -> all outputs zero next cycle; re-acceptance needs a full 4 cycles after release.
